// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: RV32I(M) opcode, funct, ALU, immediate and writeback encodings plus the control bundle type.
package decode_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;
    localparam logic [4:0] ALU_MUL  = 5'd11;

    localparam logic [2:0] IMM_U = 3'd0;
    localparam logic [2:0] IMM_J = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_I = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic       reg_write;
        logic       rs1_pc_sel;
        logic       rs2_imm_sel;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       uncond;
        logic       is_muldiv;
        logic       illegal;
        logic [1:0] wb_sel;
        logic [2:0] imm_type;
    } ctrl_t;

    function automatic logic [4:0] alu_of_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-to-decode channel.
// Ports: instr, pc, valid (fetch -> decode), ready (decode -> fetch).
interface decode_stage_if #(parameter int XLEN = 32);
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            valid;
    logic            ready;
    modport master (output instr, pc, valid, input ready);
    modport slave  (input instr, pc, valid, output ready);
endinterface

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: combinational RV32I(M) decoder producing the control bundle and illegal flag.
// Ports: instr_i (instruction word), ctrl_o (control bundle), alu_op_o (ALU operation code).
module rv_decode_comb
    import decode_stage_pkg::*;
#(
    parameter bit M_EXT    = 1'b1,
    parameter int ALU_OP_W = 5
) (
    input  logic [31:0]         instr_i,
    output ctrl_t               ctrl_o,
    output logic [ALU_OP_W-1:0] alu_op_o
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] op;
    logic       bad;
    ctrl_t      c;
    logic       unused_fields;
    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};
    always_comb begin
        c   = '0;
        op  = ALU_ADD;
        bad = 1'b0;
        case (opc)
            OP_LUI:    begin c.reg_write = 1'b1; c.rs2_imm_sel = 1'b1; c.imm_type = IMM_U; op = ALU_LUI; end
            OP_AUIPC:  begin c.reg_write = 1'b1; c.rs1_pc_sel = 1'b1; c.rs2_imm_sel = 1'b1; c.imm_type = IMM_U; end
            OP_JAL:    begin c.reg_write = 1'b1; c.rs1_pc_sel = 1'b1; c.rs2_imm_sel = 1'b1; c.imm_type = IMM_J; c.uncond = 1'b1; c.wb_sel = WB_PC4; end
            OP_JALR:   begin c.reg_write = 1'b1; c.rs2_imm_sel = 1'b1; c.imm_type = IMM_I; c.uncond = 1'b1; c.wb_sel = WB_PC4; end
            OP_BRANCH: begin c.rs1_pc_sel = 1'b1; c.rs2_imm_sel = 1'b1; c.imm_type = IMM_B; c.is_branch = 1'b1; end
            OP_LOAD:   begin c.reg_write = 1'b1; c.rs2_imm_sel = 1'b1; c.imm_type = IMM_I; c.is_load = 1'b1; c.wb_sel = WB_MEM; end
            OP_STORE:  begin c.rs2_imm_sel = 1'b1; c.imm_type = IMM_S; c.is_store = 1'b1; end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.rs2_imm_sel = 1'b1;
                c.imm_type = IMM_I;
                // funct7 is only an opcode qualifier for shifts; ADDI etc. carry immediate bits there
                op = alu_of_f3(f3, f3 == F3_SR && f7 == F7_ALT);
                bad = (f3 == F3_SLL && f7 != F7_BASE) || (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
            end
            OP_REG: begin
                c.reg_write = 1'b1;
                if (M_EXT && f7 == F7_MULDIV) begin
                    op = ALU_MUL + {2'b00, f3};
                    c.is_muldiv = 1'b1;
                end else begin
                    op = alu_of_f3(f3, f7 == F7_ALT);
                    bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            c  = '0;
            op = '0;
        end
        c.illegal = bad;
    end
    assign ctrl_o   = c;
    assign alu_op_o = ALU_OP_W'(op);
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(M) decode with valid/ready handshakes, flush and MUL/DIV issue interlock.
// Ports: clk_i/rst_i; fetch (instr/pc/valid in, ready out); flush_i; ex_ready_i;
//        ctrl_valid_o, instr_o, pc_o and the registered control bundle outputs.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit M_EXT       = 1'b1,
    parameter int ALU_OP_W    = 5,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    decode_stage_if.slave       fetch,
    input  logic                flush_i,
    input  logic                ex_ready_i,
    output logic                ctrl_valid_o,
    output logic [31:0]         instr_o,
    output logic [XLEN-1:0]     pc_o,
    output logic                reg_write_en_o,
    output logic                rs1_pc_sel_o,
    output logic                rs2_imm_sel_o,
    output logic                is_branch_instr_o,
    output logic                is_load_instr_o,
    output logic                is_store_instr_o,
    output logic                unconditional_branch_o,
    output logic                is_muldiv_o,
    output logic                illegal_instr_o,
    output logic [1:0]          wb_sel_o,
    output logic [2:0]          imm_type_o,
    output logic [ALU_OP_W-1:0] alu_op_o
);
    localparam int MAX_LAT = MUL_LATENCY > DIV_LATENCY ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = MAX_LAT > 0 ? $clog2(MAX_LAT + 1) : 1;
    ctrl_t               ctrl_d, ctrl_q;
    logic [ALU_OP_W-1:0] alu_d, alu_q;
    logic [31:0]         instr_q;
    logic [XLEN-1:0]     pc_q;
    logic                valid_d, valid_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic                handoff, accept;
    rv_decode_comb #(.M_EXT(M_EXT), .ALU_OP_W(ALU_OP_W)) u_dec (
        .instr_i  (fetch.instr),
        .ctrl_o   (ctrl_d),
        .alu_op_o (alu_d)
    );
    assign handoff     = valid_q && ex_ready_i && !flush_i;
    assign fetch.ready = !flush_i && cnt_q == '0 && (!valid_q || ex_ready_i);
    assign accept      = fetch.valid && fetch.ready;
    // funct3[2] separates DIV/REM from MUL within the M group
    always_comb begin
        valid_d = accept || (valid_q && !handoff && !flush_i);
        cnt_d   = handoff && ctrl_q.is_muldiv ? (instr_q[14] ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY))
                                              : cnt_q - CNT_W'(cnt_q != '0);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ctrl_q  <= ctrl_d;
                alu_q   <= alu_d;
                instr_q <= fetch.instr;
                pc_q    <= fetch.pc;
            end
        end
    end
    assign ctrl_valid_o           = valid_q;
    assign instr_o                = instr_q;
    assign pc_o                   = pc_q;
    assign reg_write_en_o         = ctrl_q.reg_write;
    assign rs1_pc_sel_o           = ctrl_q.rs1_pc_sel;
    assign rs2_imm_sel_o          = ctrl_q.rs2_imm_sel;
    assign is_branch_instr_o      = ctrl_q.is_branch;
    assign is_load_instr_o        = ctrl_q.is_load;
    assign is_store_instr_o       = ctrl_q.is_store;
    assign unconditional_branch_o = ctrl_q.uncond;
    assign is_muldiv_o            = ctrl_q.is_muldiv;
    assign illegal_instr_o        = ctrl_q.illegal;
    assign wb_sel_o               = ctrl_q.wb_sel;
    assign imm_type_o             = ctrl_q.imm_type;
    assign alu_op_o               = alu_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage against a cycle-level reference model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        cv, rw, pcs, ims, br, ld, st, unc, md, ill;
    logic [31:0] iout, pout;
    logic [1:0]  wb;
    logic [2:0]  it;
    logic [4:0]  alu;
    logic [31:0] nom_instr = 32'h0;
    ctrl_t       nom_ctrl;
    logic [3:0]  nom_alu;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, free_at = 0;
    logic        m_valid = 1'b0;
    logic [18:0] m_bits = '0;
    logic [31:0] m_instr = '0, m_pc = '0;
    logic        last_rdy;

    int         f3_alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage dut (
        .clk_i(clk), .rst_i(rst), .fetch(bus), .flush_i(flush), .ex_ready_i(ex_ready),
        .ctrl_valid_o(cv), .instr_o(iout), .pc_o(pout),
        .reg_write_en_o(rw), .rs1_pc_sel_o(pcs), .rs2_imm_sel_o(ims),
        .is_branch_instr_o(br), .is_load_instr_o(ld), .is_store_instr_o(st),
        .unconditional_branch_o(unc), .is_muldiv_o(md), .illegal_instr_o(ill),
        .wb_sel_o(wb), .imm_type_o(it), .alu_op_o(alu)
    );

    rv_decode_comb #(.M_EXT(1'b0), .ALU_OP_W(4)) u_nom (
        .instr_i(nom_instr), .ctrl_o(nom_ctrl), .alu_op_o(nom_alu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [18:0] obs = {ill, rw, pcs, ims, br, ld, st, unc, md, wb, it, alu};
    wire [18:0] nom_obs = {nom_ctrl.illegal, nom_ctrl.reg_write, nom_ctrl.rs1_pc_sel, nom_ctrl.rs2_imm_sel,
                           nom_ctrl.is_branch, nom_ctrl.is_load, nom_ctrl.is_store, nom_ctrl.uncond,
                           nom_ctrl.is_muldiv, nom_ctrl.wb_sel, nom_ctrl.imm_type, 1'b0, nom_alu};

    // Expected bundle {illegal, rw, pc, imm, branch, load, store, jump, muldiv, wb[2], imm_type[3], alu[5]}
    function automatic logic [18:0] model(input logic [31:0] ins, input bit mext);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [7:0] fl;
        logic [1:0] w;
        logic [2:0] t;
        int a;
        bit ok;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        fl = '0; w = 0; t = 0; a = 0; ok = 1;
        case (op)
            7'h37: begin fl = 8'b1010_0000; t = 0; a = 10; end
            7'h17: begin fl = 8'b1110_0000; t = 0; end
            7'h6F: begin fl = 8'b1110_0010; t = 1; w = 2; end
            7'h67: begin fl = 8'b1010_0010; t = 4; w = 2; end
            7'h63: begin fl = 8'b0111_0000; t = 3; end
            7'h03: begin fl = 8'b1010_1000; t = 4; w = 1; end
            7'h23: begin fl = 8'b0010_0100; t = 2; end
            7'h13: begin
                fl = 8'b1010_0000; t = 4; a = f3_alu[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) a = 7;
                    else ok = (f7 == 0);
                end
            end
            7'h33: begin
                fl = 8'b1000_0000;
                if (f7 == 0) a = f3_alu[f3];
                else if (f7 == 7'h20 && f3 == 0) a = 1;
                else if (f7 == 7'h20 && f3 == 5) a = 7;
                else if (f7 == 7'h01 && mext) begin a = 11 + int'(f3); fl[0] = 1'b1; end
                else ok = 0;
            end
            default: ok = 0;
        endcase
        return ok ? {1'b0, fl, w, t, a[4:0]} : {1'b1, 18'b0};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: return w;
            1: return {w[31:7], 7'h33};
            2: return {7'h01, w[24:7], 7'h33};
            3: return {7'h00, w[24:7], $urandom_range(0, 1) ? 7'h33 : 7'h13};
            4: return {7'h20, w[24:7], $urandom_range(0, 1) ? 7'h33 : 7'h13};
            default: return {w[31:7], ops[$urandom_range(0, 8)]};
        endcase
    endfunction

    // One clock of stimulus with the reference model advanced alongside
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic exr, input logic fl);
        logic exp_rdy, hand;
        @(negedge clk);
        bus.valid = v; bus.instr = ins; bus.pc = p; ex_ready = exr; flush = fl;
        #1;
        exp_rdy = !fl && cyc >= free_at && (!m_valid || exr);
        last_rdy = bus.ready;
        n_cmp++;
        if (bus.ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL instr_ready cyc=%0d got %b want %b", cyc, bus.ready, exp_rdy);
        end
        hand = m_valid && exr && !fl;
        if (hand && m_bits[10]) free_at = cyc + 1 + (m_instr[14] ? 32 : 3);
        if (v && exp_rdy) begin
            m_valid = 1'b1; m_bits = model(ins, 1); m_instr = ins; m_pc = p;
        end else if (hand || fl) m_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (cv !== m_valid) begin
            n_bad++;
            $display("FAIL ctrl_valid cyc=%0d got %b want %b", cyc, cv, m_valid);
        end
        if (m_valid) begin
            n_cmp++;
            if (obs !== m_bits) begin
                n_bad++;
                $display("FAIL bundle instr=%h got %b want %b", m_instr, obs, m_bits);
            end
            n_cmp++;
            if ({iout, pout} !== {m_instr, m_pc}) begin
                n_bad++;
                $display("FAIL instr_pc got %h/%h want %h/%h", iout, pout, m_instr, m_pc);
            end
        end
    endtask

    // Idle until instr_ready rises again; returns how many cycles it stayed low
    task automatic count_stall(input logic flush_first, output int low);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, flush_first && i == 0);
            if (last_rdy) break;
            low++;
        end
    endtask

    task automatic test_reset();
        bus.valid = 1'b0; bus.instr = '0; bus.pc = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cv, obs, iout, pout} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b/%b/%h/%h want all zero", cv, obs, iout, pout);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 1", bus.ready);
        end
    endtask

    task automatic test_add();
        step(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
        n_cmp++;
        if ({cv, alu, rw, wb, ims, ill} !== {1'b1, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_fields got v%b a%0d rw%b wb%b imm%b ill%b want v1 a0 rw1 wb00 imm0 ill0",
                     cv, alu, rw, wb, ims, ill);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_load_stall();
        step(1'b1, 32'h0080A283, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h002081B3, 32'h204, 1'b0, 1'b0);
        n_cmp++;
        if ({cv, ld, it, wb, iout} !== {1'b1, 1'b1, 3'b100, 2'b01, 32'h0080A283}) begin
            n_bad++;
            $display("FAIL load_held got v%b ld%b it%b wb%b i%h want v1 ld1 it100 wb01 i0080a283",
                     cv, ld, it, wb, iout);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_mul();
        int low;
        step(1'b1, 32'h022081B3, 32'h300, 1'b1, 1'b0);
        n_cmp++;
        if ({alu, md} !== {5'd11, 1'b1}) begin
            n_bad++;
            $display("FAIL mul_fields got a%0d md%b want a11 md1", alu, md);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        count_stall(1'b0, low);
        n_cmp++;
        if (low != 3) begin
            n_bad++;
            $display("FAIL mul_stall got %0d cycles want 3", low);
        end
    endtask

    task automatic test_div();
        int low;
        nom_instr = 32'h0220C1B3;
        #1;
        n_cmp++;
        if (nom_obs !== {1'b1, 18'b0}) begin
            n_bad++;
            $display("FAIL div_no_mext got %b want illegal only", nom_obs);
        end
        step(1'b1, 32'h0220C1B3, 32'h400, 1'b1, 1'b0);
        n_cmp++;
        if ({alu, md, ill} !== {5'd15, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL div_fields got a%0d md%b ill%b want a15 md1 ill0", alu, md, ill);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        count_stall(1'b0, low);
        n_cmp++;
        if (low != 32) begin
            n_bad++;
            $display("FAIL div_stall got %0d cycles want 32", low);
        end
    endtask

    task automatic test_no_mext();
        logic [31:0] w;
        for (int i = 0; i < 40; i++) begin
            w = (i == 0) ? 32'h022081B3 : rand_instr();
            nom_instr = w;
            #1;
            n_cmp++;
            if (nom_obs !== model(w, 0)) begin
                n_bad++;
                $display("FAIL no_mext instr=%h got %b want %b", w, nom_obs, model(w, 0));
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [2] = '{32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 2; i++) begin
            step(1'b1, words[i], 32'h500, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== {1'b1, 18'b0} || $isunknown({cv, obs, iout, pout})) begin
                n_bad++;
                $display("FAIL illegal instr=%h got %b want illegal only, no X", words[i], obs);
            end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        int low;
        step(1'b1, 32'h002081B3, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'h40208133, 32'h604, 1'b1, 1'b1);
        n_cmp++;
        if ({cv, iout} !== {1'b0, 32'h002081B3}) begin
            n_bad++;
            $display("FAIL flush_drop got v%b i%h want v0 i002081b3", cv, iout);
        end
        step(1'b1, 32'h022081B3, 32'h608, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        count_stall(1'b1, low);
        n_cmp++;
        if (low != 3) begin
            n_bad++;
            $display("FAIL flush_keeps_busy got %0d cycles want 3", low);
        end
    endtask

    task automatic test_reset_mid_div();
        step(1'b1, 32'h0220C1B3, 32'h700, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (cv !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_valid got %b want 0", cv);
        end
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        free_at = 0;
        #1;
        n_cmp++;
        if (bus.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_ready got %b want 1", bus.ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_stall();
        test_mul();
        test_div();
        test_no_mext();
        test_illegal();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
